ascon_absorb_buffer: RTL and testbench

Input-side buffer of the ASCON-AEAD128 core. It collects 32-bit data words from the host interface into 128-bit rate blocks and applies ASCON-AEAD128 padding. Each padded block drives the data input of the 2:1 selector in front of the state absorb XOR. A valid/ready handshake is used on both sides, so the permutation controller pulls exactly one block per absorb step.

---
 rtl/ascon_pkg.sv | 6 +
 rtl/ascon_pad_word.sv | 17 +
 rtl/ascon_absorb_buffer.sv | 93 +++++++++
 tb/tb_ascon_absorb_buffer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// ascon_pkg: shared FSM encoding and byte constants for the ASCON absorb buffer.
package ascon_pkg;
    typedef enum logic [1:0] {FILL, EMIT, EXTRA} absorb_state_t;
    localparam logic [4:0] RATE_BYTES = 5'd16;
    localparam logic [7:0] PAD_BYTE   = 8'h01;
endpackage

// File: rtl/ascon_pad_word.sv
// ascon_pad_word: masks invalid bytes of a 32-bit word and inserts the 0x01 pad byte.
module ascon_pad_word
    import ascon_pkg::*;
(
    input  logic [31:0] din_i,
    input  logic [2:0]  bytes_i,
    input  logic        pad_en_i,
    output logic [31:0] word_o
);
    logic [2:0] nb;
    always_comb begin
        nb = bytes_i > 3'd4 ? 3'd4 : bytes_i;
        for (int k = 0; k < 4; k++)
            word_o[8*k +: 8] = (3'(k) < nb) ? din_i[8*k +: 8] :
                               (pad_en_i && 3'(k) == nb) ? PAD_BYTE : 8'h00;
    end
endmodule

// File: rtl/ascon_absorb_buffer.sv
// ascon_absorb_buffer: packs 32-bit words into padded 128-bit rate blocks with valid/ready on both sides.
module ascon_absorb_buffer
    import ascon_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  din,
    input  logic [2:0]   din_bytes,
    input  logic         din_last,
    input  logic         din_valid,
    output logic         din_ready,
    output logic [127:0] blk,
    output logic         blk_last,
    output logic         blk_valid,
    input  logic         blk_ready
);
    absorb_state_t state_q, state_d;
    logic [127:0]  buf_q, buf_d;
    logic [1:0]    wc_q, wc_d;
    logic          xpad_q, xpad_d, last_q, last_d;
    logic [31:0]   pw;
    logic [2:0]    nb;
    logic [4:0]    n;
    logic [6:0]    wbit;

    assign nb   = din_bytes > 3'd4 ? 3'd4 : din_bytes;
    assign n    = {1'b0, wc_q, 2'b00} + {2'b00, nb};
    assign wbit = {wc_q, 5'd0};

    ascon_pad_word u_pad (
        .din_i    (din),
        .bytes_i  (din_bytes),
        .pad_en_i (din_last),
        .word_o   (pw)
    );

    assign din_ready = state_q == FILL;
    assign blk_valid = state_q != FILL;
    assign blk       = state_q == EXTRA ? 128'h1 : buf_q;
    assign blk_last  = state_q == EXTRA || (state_q == EMIT && last_q);

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        wc_d    = wc_q;
        xpad_d  = xpad_q;
        last_d  = last_q;
        case (state_q)
            FILL: if (din_valid && (nb != 3'd0 || din_last)) begin
                buf_d[wbit +: 32] = pw;
                if (din_last) begin
                    // a full last word pushes the pad byte into the next (already zero) word slot
                    if (nb == 3'd4 && n < RATE_BYTES) buf_d[wbit + 7'd32 +: 8] = PAD_BYTE;
                    state_d = EMIT;
                    last_d  = n < RATE_BYTES;
                    xpad_d  = n == RATE_BYTES;
                end else begin
                    wc_d = wc_q + 2'd1;
                    if (wc_q == 2'd3) begin
                        state_d = EMIT;
                        last_d  = 1'b0;
                    end
                end
            end
            EMIT: if (blk_ready) begin
                buf_d   = '0;
                wc_d    = '0;
                state_d = xpad_q ? EXTRA : FILL;
            end
            EXTRA: if (blk_ready) begin
                xpad_d  = 1'b0;
                state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            buf_q   <= '0;
            wc_q    <= '0;
            xpad_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            wc_q    <= wc_d;
            xpad_q  <= xpad_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_ascon_absorb_buffer.sv
// tb_ascon_absorb_buffer: table-driven message vectors plus hand sequences for reset and backpressure.
module tb_ascon_absorb_buffer;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  din;
    logic [2:0]   din_bytes;
    logic         din_last, din_valid, din_ready;
    logic [127:0] blk;
    logic         blk_last, blk_valid, blk_ready;
    int           total = 0;
    int           bad = 0;

    ascon_absorb_buffer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_bytes (din_bytes),
        .din_last  (din_last),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .blk       (blk),
        .blk_last  (blk_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] words;
        int           nwords;
        logic [2:0]   last_bytes;
        logic [127:0] exp_blk;
        logic         exp_last;
        logic         extra;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic [2:0] nb, input logic last);
        din = w;
        din_bytes = nb;
        din_last = last;
        din_valid = 1'b1;
        for (int t = 0; t < 20 && !din_ready; t++) @(negedge clk);
        if (!din_ready) chk("send_timeout", 128'(din_ready), 128'h1);
        @(posedge clk);
        #1 din_valid = 1'b0;
    endtask

    task automatic get_block(input string nm, input logic [127:0] exp, input logic exp_last);
        for (int t = 0; t < 20 && !blk_valid; t++) @(negedge clk);
        if (!blk_valid) chk({nm, "_timeout"}, 128'(blk_valid), 128'h1);
        else begin
            chk({nm, "_blk"}, blk, exp);
            chk({nm, "_last"}, 128'(blk_last), 128'(exp_last));
        end
        blk_ready = 1'b1;
        @(posedge clk);
        #1 blk_ready = 1'b0;
    endtask

    vec_t vecs[7];
    logic [127:0] held;

    initial begin
        vecs[0] = '{128'h0F0E0D0C_0B0A0908_07060504_03020100, 4, 3'd4,
                    128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b0, 1'b1};
        vecs[1] = '{128'h0_FFFFFF04_03020100, 2, 3'd1,
                    128'h00000000_00000000_00000104_03020100, 1'b1, 1'b0};
        vecs[2] = '{128'h12345678, 1, 3'd0, 128'h1, 1'b1, 1'b0};
        vecs[3] = '{128'hAABBCCDD, 1, 3'd4, 128'h01_AABBCCDD, 1'b1, 1'b0};
        vecs[4] = '{128'h11223344, 1, 3'd3, 128'h01223344, 1'b1, 1'b0};
        vecs[5] = '{128'h11111111_22222222_33333333, 3, 3'd4,
                    128'h00000001_11111111_22222222_33333333, 1'b1, 1'b0};
        vecs[6] = '{128'hFFFF1234_C0C0C0C0_B0B0B0B0_A0A0A0A0, 4, 3'd2,
                    128'h00011234_C0C0C0C0_B0B0B0B0_A0A0A0A0, 1'b1, 1'b0};

        rst_n = 1'b0;
        din = 32'hDEADBEEF;
        din_bytes = 3'd4;
        din_last = 1'b0;
        din_valid = 1'b1;
        blk_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        din_valid = 1'b0;
        @(negedge clk);
        chk("rst_blk_valid", 128'(blk_valid), 128'h0);
        chk("rst_blk", blk, 128'h0);
        chk("rst_blk_last", 128'(blk_last), 128'h0);
        chk("rst_din_ready", 128'(din_ready), 128'h1);
        @(posedge clk);
        #1;
        send_word(32'h0, 3'd0, 1'b1);
        chk("empty_latency", 128'(blk_valid), 128'h1);
        get_block("post_rst_empty", 128'h1, 1'b1);

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < vecs[v].nwords; i++)
                send_word(vecs[v].words[32*i +: 32],
                          i == vecs[v].nwords - 1 ? vecs[v].last_bytes : 3'd4,
                          i == vecs[v].nwords - 1);
            get_block($sformatf("vec%0d", v), vecs[v].exp_blk, vecs[v].exp_last);
            if (vecs[v].extra) get_block($sformatf("vec%0d_extra", v), 128'h1, 1'b1);
            chk($sformatf("vec%0d_ready_after", v), 128'(din_ready), 128'h1);
        end

        send_word(32'h99999999, 3'd0, 1'b0);
        send_word(32'hDDCCBBAA, 3'd2, 1'b1);
        get_block("zero_byte_word", 128'h0001BBAA, 1'b1);

        send_word(32'h44332211, 3'd7, 1'b1);
        get_block("bytes7", 128'h01_44332211, 1'b1);

        send_word(32'h11111111, 3'd4, 1'b1);
        held = blk;
        chk("bp_blk", held, 128'h01_11111111);
        din = 32'hFFFFFFFF;
        din_bytes = 3'd4;
        din_last = 1'b1;
        din_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("bp_stable%0d", c), blk, held);
            chk($sformatf("bp_last%0d", c), 128'(blk_last), 128'h1);
            chk($sformatf("bp_ready%0d", c), 128'(din_ready), 128'h0);
        end
        @(posedge clk);
        #1 din_valid = 1'b0;
        blk_ready = 1'b1;
        @(negedge clk);
        chk("bp_final_blk", blk, held);
        @(posedge clk);
        #1 blk_ready = 1'b0;
        chk("bp_ready_after", 128'(din_ready), 128'h1);
        chk("bp_cleared", blk, 128'h0);

        send_word(32'h03020100, 3'd4, 1'b0);
        send_word(32'h07060504, 3'd4, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_word(32'h000000AA, 3'd1, 1'b1);
        get_block("mid_rst", 128'h01AA, 1'b1);

        send_word(32'h03020100, 3'd4, 1'b0);
        send_word(32'h07060504, 3'd4, 1'b0);
        send_word(32'h0B0A0908, 3'd4, 1'b0);
        send_word(32'h0F0E0D0C, 3'd4, 1'b1);
        for (int t = 0; t < 20 && !blk_valid; t++) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_drops_extra", 128'(blk_valid), 128'h0);
        chk("rst_drops_extra_blk", blk, 128'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
